ps2_host_tx: RTL



---
 rtl/ps2_pkg.sv | 29 ++
 rtl/ps2_line_sync.sv | 37 +++
 rtl/ps2_host_tx.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ps2_pkg : PS/2 host-side state encoding, timing helper, frame bit counts
// Rev 1.0
// ----------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_REQ     = 3'd2,
    ST_WAIT1   = 3'd3,
    ST_SHIFT   = 3'd4,
    ST_ACK     = 3'd5,
    ST_RECOV   = 3'd6,
    ST_ERR     = 3'd7
  } ps2_state_t;

  // Falling edge that releases data for the stop bit, and the one that samples ACK
  localparam int STOP_EDGE = 10;
  localparam int ACK_EDGE  = 11;

  // 64-bit intermediate keeps khz*us exact for clocks up to 100 MHz
  function automatic int us_to_cycles(input longint khz, input longint us);
    return int'((khz * us) / 64'd1000);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ps2_line_sync : 2-FF synchronizer for PS/2 clock/data, registered clock fall
// Rev 1.0
// ----------------------------------------------------------------------------
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic clk_pin,
  input  logic data_pin,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic clk_meta;
  logic data_meta;

  // Idle bus is pulled high, so the synchronizer resets to released lines
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
      clk_fall  <= 1'b0;
    end else begin
      clk_meta  <= clk_pin;
      clk_sync  <= clk_meta;
      data_meta <= data_pin;
      data_sync <= data_meta;
      clk_fall  <= clk_sync & ~clk_meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ps2_host_tx : host-to-device PS/2 command transmitter (optional PS2_TX_ACK_CHECK_EN)
// Rev 1.0
// ----------------------------------------------------------------------------
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_KHZ      = 28000,
  parameter int INHIBIT_US   = 120,
  parameter int REQ_US       = 20,
  parameter int START_TMO_US = 15000,
  parameter int PKT_TMO_US   = 2000
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire        ps2clk_ext,
  inout  wire        ps2data_ext,
  input  logic [7:0] data,
  input  logic       dataload,
  output logic       ps2busy,
  output logic       ps2error,
  output logic       done
);

  localparam int INHIBIT_CYC   = us_to_cycles(CLK_KHZ, INHIBIT_US);
  localparam int REQ_CYC       = us_to_cycles(CLK_KHZ, REQ_US);
  localparam int START_TMO_CYC = us_to_cycles(CLK_KHZ, START_TMO_US);
  localparam int PKT_TMO_CYC   = us_to_cycles(CLK_KHZ, PKT_TMO_US);
  localparam int TMR_W         = $clog2(START_TMO_CYC + 1);

  localparam logic [TMR_W-1:0] INHIBIT_LAST = TMR_W'(INHIBIT_CYC - 1);
  localparam logic [TMR_W-1:0] REQ_LAST     = TMR_W'(REQ_CYC - 1);
  localparam logic [TMR_W-1:0] START_LAST   = TMR_W'(START_TMO_CYC - 1);
  localparam logic [TMR_W-1:0] PKT_LAST     = TMR_W'(PKT_TMO_CYC - 1);

  ps2_state_t       state;
  logic [TMR_W-1:0] timer;
  logic [3:0]       bit_cnt;
  logic [9:0]       frame;
  logic             clk_low;
  logic             data_low;
  logic             clk_sync;
  logic             data_sync;
  logic             clk_fall;
  logic             fail;

  assign ps2clk_ext  = clk_low  ? 1'b0 : 1'bz;
  assign ps2data_ext = data_low ? 1'b0 : 1'bz;

  ps2_line_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .clk_pin  (ps2clk_ext),
    .data_pin (ps2data_ext),
    .clk_sync (clk_sync),
    .data_sync(data_sync),
    .clk_fall (clk_fall)
  );

  // A device edge arriving on the last start-timer cycle still counts as in time
  always_comb begin
    fail = 1'b0;
    case (state)
      ST_WAIT1:           fail = !clk_fall && (timer == START_LAST);
      ST_SHIFT, ST_RECOV: fail = (timer == PKT_LAST);
`ifdef PS2_TX_ACK_CHECK_EN
      ST_ACK:             fail = (timer == PKT_LAST) || (clk_fall && data_sync);
`else
      ST_ACK:             fail = (timer == PKT_LAST);
`endif
      default:            fail = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      timer    <= '0;
      bit_cnt  <= '0;
      frame    <= '0;
      clk_low  <= 1'b0;
      data_low <= 1'b0;
      ps2busy  <= 1'b0;
      ps2error <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (fail) begin
        clk_low  <= 1'b0;
        data_low <= 1'b0;
        ps2error <= 1'b1;
        ps2busy  <= 1'b0;
        state    <= ST_ERR;
      end else begin
        case (state)
          ST_IDLE: begin
            if (dataload) begin
              frame    <= {1'b1, ~^data, data};
              ps2error <= 1'b0;
              ps2busy  <= 1'b1;
              clk_low  <= 1'b1;
              timer    <= '0;
              state    <= ST_INHIBIT;
            end
          end
          ST_INHIBIT: begin
            if (timer == INHIBIT_LAST) begin
              timer    <= '0;
              data_low <= 1'b1;
              state    <= ST_REQ;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          ST_REQ: begin
            if (timer == REQ_LAST) begin
              timer   <= '0;
              clk_low <= 1'b0;
              state   <= ST_WAIT1;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          ST_WAIT1: begin
            if (clk_fall) begin
              timer    <= '0;
              data_low <= ~frame[0];
              bit_cnt  <= 4'd1;
              state    <= ST_SHIFT;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          ST_SHIFT: begin
            timer <= timer + 1'b1;
            if (clk_fall) begin
              data_low <= ~frame[bit_cnt];
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == 4'(STOP_EDGE - 1)) state <= ST_ACK;
            end
          end
          ST_ACK: begin
            timer <= timer + 1'b1;
            if (clk_fall && (bit_cnt == 4'(ACK_EDGE - 1))) begin
              bit_cnt <= bit_cnt + 1'b1;
              state   <= ST_RECOV;
            end
          end
          ST_RECOV: begin
            timer <= timer + 1'b1;
            if (clk_sync && data_sync) begin
              done    <= 1'b1;
              ps2busy <= 1'b0;
              state   <= ST_IDLE;
            end
          end
          ST_ERR:  state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
